// File: rtl/cpu_axi_bridge.sv
`default_nettype none
// cpu_axi_bridge (rev 1.0): merges instruction and data SRAM-like ports onto one AXI3 master.
// Data reads and writes never overlap, so the data port completes in issue order.
module cpu_axi_bridge #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int MAX_RD = 2,
  parameter int MAX_WR = 2,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [STRB_W-1:0] inst_wstrb,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [STRB_W-1:0] data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [1:0]        arlock,
  output logic [3:0]        arcache,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic [3:0]        awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic [1:0]        awlock,
  output logic [3:0]        awcache,
  output logic [2:0]        awprot,
  output logic              awvalid,
  input  logic              awready,
  output logic [3:0]        wid,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [3:0]        bid,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  localparam int OFF = $clog2(STRB_W);
  localparam int TW  = ADDR_W - OFF;
  localparam int RCW = $clog2(MAX_RD + 1);
  localparam int WCW = $clog2(MAX_WR + 1);
  localparam int PW  = (MAX_WR > 1) ? $clog2(MAX_WR) : 1;

  logic [RCW-1:0]    inst_rd_cnt, data_rd_cnt;
  logic [WCW-1:0]    wr_cnt;
  logic [TW-1:0]     pend_addr [MAX_WR];
  logic [MAX_WR-1:0] pend_vld;
  logic [PW-1:0]     push_ptr, pop_ptr;

  logic r_hs, b_hs, r_inst, r_data;
  logic inst_dec, data_dec, wr_dec;
  logic data_rd_ok, data_wr_ok, inst_rd_ok, addr_hit;
  logic unused_ok;

  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign awid    = 4'd1;
  assign awlen   = 8'd0;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign wid     = 4'd1;
  assign wlast   = 1'b1;
  assign rready  = 1'b1;
  // Hold off B while a data-port R beat is presented so data_data_ok never doubles up.
  assign bready  = !(rvalid && rid == 4'd1);

  assign r_hs     = rvalid && rready;
  assign b_hs     = bvalid && bready;
  assign r_inst   = r_hs && rid == 4'd0;
  assign r_data   = r_hs && rid == 4'd1;
  assign inst_dec = r_inst && inst_rd_cnt != '0;
  assign data_dec = r_data && data_rd_cnt != '0;
  assign wr_dec   = b_hs && wr_cnt != '0;

  assign data_rd_ok = !reset && data_req && !data_wr && !arvalid
                      && data_rd_cnt < RCW'(MAX_RD) && wr_cnt == '0;
  assign data_wr_ok = !reset && data_req && data_wr && !awvalid && !wvalid
                      && wr_cnt < WCW'(MAX_WR) && data_rd_cnt == '0;

  // A write accepted this very cycle also counts as pending for the hazard check.
  always_comb begin
    addr_hit = data_wr_ok && (data_addr[ADDR_W-1:OFF] == inst_addr[ADDR_W-1:OFF]);
    for (int i = 0; i < MAX_WR; i++) begin
      if (pend_vld[i] && pend_addr[i] == inst_addr[ADDR_W-1:OFF]) addr_hit = 1'b1;
    end
  end

  assign inst_rd_ok = !reset && inst_req && !inst_wr && !arvalid
                      && inst_rd_cnt < RCW'(MAX_RD) && !addr_hit && !data_rd_ok;

  assign inst_addr_ok = inst_rd_ok;
  assign data_addr_ok = data_rd_ok || data_wr_ok;

  assign unused_ok = &{1'b0, rresp, bresp, bid, rlast, inst_wdata, inst_wstrb};

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(MAX_WR - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      arvalid      <= 1'b0;
      araddr       <= '0;
      arsize       <= '0;
      arid         <= '0;
      awvalid      <= 1'b0;
      wvalid       <= 1'b0;
      awaddr       <= '0;
      awsize       <= '0;
      wdata        <= '0;
      wstrb        <= '0;
      inst_rd_cnt  <= '0;
      data_rd_cnt  <= '0;
      wr_cnt       <= '0;
      pend_vld     <= '0;
      push_ptr     <= '0;
      pop_ptr      <= '0;
      inst_rdata   <= '0;
      data_rdata   <= '0;
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      for (int i = 0; i < MAX_WR; i++) pend_addr[i] <= '0;
    end else begin
      if (data_rd_ok || inst_rd_ok) begin
        arvalid <= 1'b1;
        araddr  <= data_rd_ok ? data_addr : inst_addr;
        arsize  <= {1'b0, (data_rd_ok ? data_size : inst_size)};
        arid    <= data_rd_ok ? 4'd1 : 4'd0;
      end else if (arready) begin
        arvalid <= 1'b0;
      end

      if (data_wr_ok) begin
        awvalid <= 1'b1;
        wvalid  <= 1'b1;
        awaddr  <= data_addr;
        awsize  <= {1'b0, data_size};
        wdata   <= data_wdata;
        wstrb   <= data_wstrb;
      end else begin
        if (awready) awvalid <= 1'b0;
        if (wready)  wvalid  <= 1'b0;
      end

      if (inst_rd_ok && !inst_dec)      inst_rd_cnt <= inst_rd_cnt + 1'b1;
      else if (!inst_rd_ok && inst_dec) inst_rd_cnt <= inst_rd_cnt - 1'b1;
      if (data_rd_ok && !data_dec)      data_rd_cnt <= data_rd_cnt + 1'b1;
      else if (!data_rd_ok && data_dec) data_rd_cnt <= data_rd_cnt - 1'b1;
      if (data_wr_ok && !wr_dec)        wr_cnt <= wr_cnt + 1'b1;
      else if (!data_wr_ok && wr_dec)   wr_cnt <= wr_cnt - 1'b1;

      if (wr_dec) begin
        pend_vld[pop_ptr] <= 1'b0;
        pop_ptr           <= ptr_next(pop_ptr);
      end
      if (data_wr_ok) begin
        pend_vld[push_ptr]  <= 1'b1;
        pend_addr[push_ptr] <= data_addr[ADDR_W-1:OFF];
        push_ptr            <= ptr_next(push_ptr);
      end

      inst_data_ok <= r_inst;
      data_data_ok <= r_data || b_hs;
      if (r_inst) inst_rdata <= rdata;
      if (r_data) data_rdata <= rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_axi_bridge.sv
`default_nettype none
// tb_cpu_axi_bridge: directed AXI responder with per-port expected-data queues.
module tb_cpu_axi_bridge;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, inst_rdata, data_addr, data_wdata, data_rdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [3:0]  arid, rid, awid, wid, bid, arcache, awcache, wstrb;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, rresp, awburst, awlock, bresp;
  logic        arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic        wlast, wvalid, wready, bvalid, bready;

  cpu_axi_bridge dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int total = 0;
  int bad = 0;
  logic [31:0] inst_q[$];
  logic [31:0] data_q[$];
  logic [31:0] last_data = 32'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every data_ok pulse consumes one expectation of its port.
  always @(negedge clk) begin
    if (inst_data_ok) begin
      if (inst_q.size() == 0) chk("inst_data_ok_unexpected", inst_data_ok, 0);
      else chk("inst_rdata", inst_rdata, inst_q.pop_front());
    end
    if (data_data_ok) begin
      if (data_q.size() == 0) chk("data_data_ok_unexpected", data_data_ok, 0);
      else chk("data_rdata", data_rdata, data_q.pop_front());
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ar_hs(input logic [3:0] id, input logic [31:0] addr);
    int n = 0;
    while (!arvalid && n < 20) begin cyc(); n++; end
    chk("ar_wait_arvalid", arvalid, 1);
    chk("arid", arid, id);
    chk("araddr", araddr, addr);
    arready = 1'b1;
    cyc();
    arready = 1'b0;
  endtask

  task automatic aw_hs(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    while (!(awvalid && wvalid) && n < 20) begin cyc(); n++; end
    chk("aw_wait_valid", awvalid && wvalid, 1);
    chk("awaddr", awaddr, addr);
    chk("wdata", wdata, d);
    chk("wstrb", wstrb, s);
    chk("aw_ids_last", {awid, wid, wlast}, {4'd1, 4'd1, 1'b1});
    awready = 1'b1;
    wready  = 1'b1;
    cyc();
    awready = 1'b0;
    wready  = 1'b0;
  endtask

  task automatic r_send(input logic [3:0] id, input logic [31:0] d);
    rvalid = 1'b1; rid = id; rdata = d; rlast = 1'b1;
    cyc();
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;

    // Reset: requests present but nothing may be accepted.
    repeat (2) cyc();
    inst_req = 1; inst_addr = 32'h1FC00000; data_req = 1; #1;
    chk("rst_inst_addr_ok", inst_addr_ok, 0);
    chk("rst_data_addr_ok", data_addr_ok, 0);
    chk("rst_valids", {arvalid, awvalid, wvalid}, 3'b000);
    chk("rst_counts", {dut.inst_rd_cnt, dut.data_rd_cnt, dut.wr_cnt}, 6'd0);
    inst_req = 0; data_req = 0;
    cyc(); reset = 0; cyc();

    // Single inst read with minimum latency.
    inst_req = 1; inst_addr = 32'h1FC00000; inst_size = 2'd2; #1;
    chk("t1_addr_ok", inst_addr_ok, 1);
    inst_q.push_back(32'hDEADBEEF);
    cyc(); inst_req = 0;
    chk("t1_arvalid", arvalid, 1);
    chk("t1_araddr", araddr, 32'h1FC00000);
    chk("t1_arid", arid, 0);
    chk("t1_ar_fields", {arsize, arlen, arburst, arlock, arcache, arprot}, {3'd2, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0});
    arready = 1; cyc(); arready = 0;
    chk("t1_arvalid_drop", arvalid, 0);
    rvalid = 1; rid = 0; rdata = 32'hDEADBEEF; rlast = 1; #1;
    chk("t1_rready", rready, 1);
    cyc(); rvalid = 0; rlast = 0;
    chk("t1_data_ok_latency", inst_data_ok, 1);
    cyc();
    chk("t1_data_ok_pulse", inst_data_ok, 0);
    chk("t1_counts", {dut.inst_rd_cnt, dut.data_rd_cnt, dut.wr_cnt}, 6'd0);

    // Simultaneous inst and data reads; data wins, responses return inst first.
    inst_req = 1; inst_addr = 32'h00001000; data_req = 1; data_wr = 0; data_addr = 32'h00002000; #1;
    chk("t2_data_addr_ok", data_addr_ok, 1);
    chk("t2_inst_loses", inst_addr_ok, 0);
    data_q.push_back(32'h22222222); last_data = 32'h22222222;
    inst_q.push_back(32'h11111111);
    cyc(); data_req = 0; #1;
    chk("t2_inst_wait_ar", inst_addr_ok, 0);
    chk("t2_arid_data", arid, 1);
    chk("t2_araddr_data", araddr, 32'h00002000);
    arready = 1; cyc(); arready = 0; #1;
    chk("t2_inst_after_ar", inst_addr_ok, 1);
    cyc(); inst_req = 0;
    ar_hs(4'd0, 32'h00001000);
    r_send(4'd0, 32'h11111111);
    r_send(4'd1, 32'h22222222);
    cyc();
    chk("t2_counts", {dut.inst_rd_cnt, dut.data_rd_cnt}, 4'd0);

    // Data write then inst read of the same word: blocked until B.
    data_req = 1; data_wr = 1; data_addr = 32'h80000010; data_wdata = 32'hCAFEF00D; data_wstrb = 4'hF; #1;
    chk("t3_wr_addr_ok", data_addr_ok, 1);
    data_q.push_back(last_data);
    cyc(); data_req = 0; data_wr = 0;
    aw_hs(32'h80000010, 32'hCAFEF00D, 4'hF);
    inst_req = 1; inst_addr = 32'h80000014; #1;
    chk("t3_other_word_ok", inst_addr_ok, 1);
    inst_addr = 32'h80000010; #1;
    chk("t3_blocked", inst_addr_ok, 0);
    cyc(); cyc(); #1;
    chk("t3_still_blocked", inst_addr_ok, 0);
    bvalid = 1; #1;
    chk("t3_bready", bready, 1);
    cyc(); bvalid = 0; #1;
    chk("t3_unblocked", inst_addr_ok, 1);
    inst_q.push_back(32'h12345678);
    cyc(); inst_req = 0;
    ar_hs(4'd0, 32'h80000010);
    r_send(4'd0, 32'h12345678);
    cyc();
    chk("t3_counts", {dut.inst_rd_cnt, dut.wr_cnt}, 4'd0);

    // Outstanding-read limit on the inst port.
    inst_req = 1; inst_addr = 32'h00000100; #1;
    chk("t4_first_ok", inst_addr_ok, 1);
    inst_q.push_back(32'h000000A0);
    cyc(); inst_req = 0;
    ar_hs(4'd0, 32'h00000100);
    inst_req = 1; inst_addr = 32'h00000104; #1;
    chk("t4_second_ok", inst_addr_ok, 1);
    inst_q.push_back(32'h000000A1);
    cyc(); inst_req = 0;
    ar_hs(4'd0, 32'h00000104);
    inst_req = 1; inst_addr = 32'h00000108; #1;
    chk("t4_third_blocked", inst_addr_ok, 0);
    cyc(); #1;
    chk("t4_third_blocked2", inst_addr_ok, 0);
    rvalid = 1; rid = 0; rdata = 32'h000000A0; rlast = 1; #1;
    chk("t4_blocked_during_r", inst_addr_ok, 0);
    cyc(); rvalid = 0; rlast = 0; #1;
    chk("t4_third_ok", inst_addr_ok, 1);
    inst_q.push_back(32'h000000A2);
    cyc(); inst_req = 0;
    ar_hs(4'd0, 32'h00000108);
    r_send(4'd0, 32'h000000A1);
    r_send(4'd0, 32'h000000A2);
    cyc();
    chk("t4_inst_cnt", dut.inst_rd_cnt, 0);

    // R (rid=1) and B in the same cycle: B deferred, two data_ok pulses.
    data_req = 1; data_wr = 1; data_addr = 32'h80000020; data_wdata = 32'h55AA55AA; data_wstrb = 4'h3; #1;
    chk("t5_wr_addr_ok", data_addr_ok, 1);
    cyc(); data_req = 0; data_wr = 0;
    aw_hs(32'h80000020, 32'h55AA55AA, 4'h3);
    rvalid = 1; rid = 1; rdata = 32'h77777777; rlast = 1; bvalid = 1; #1;
    chk("t5_bready_low", bready, 0);
    data_q.push_back(32'h77777777);
    data_q.push_back(32'h77777777);
    last_data = 32'h77777777;
    cyc(); rvalid = 0; rlast = 0; #1;
    chk("t5_bready_high", bready, 1);
    chk("t5_first_ok", data_data_ok, 1);
    cyc(); bvalid = 0;
    chk("t5_second_ok", data_data_ok, 1);
    cyc();
    chk("t5_counts", {dut.data_rd_cnt, dut.wr_cnt}, 4'd0);

    // Reset while arvalid is high abandons the read.
    inst_req = 1; inst_addr = 32'h00000200; #1;
    chk("t6_addr_ok", inst_addr_ok, 1);
    cyc(); inst_req = 0;
    chk("t6_arvalid", arvalid, 1);
    reset = 1;
    cyc(); reset = 0;
    chk("t6_arvalid_cleared", arvalid, 0);
    chk("t6_counts", {dut.inst_rd_cnt, dut.data_rd_cnt, dut.wr_cnt}, 6'd0);
    repeat (4) cyc();

    chk("inst_q_drained", inst_q.size(), 0);
    chk("data_q_drained", data_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/cpu_axi_bridge.md
CPU_AXI_BRIDGE -- requirements
Module: cpu_axi_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning AXI/SRAM data width (32 or 64); STRB_W=DATA_W/8.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-003 SHALL have parameter MAX_RD, default 2, meaning max outstanding reads per port (1..4).
REQ-004 SHALL have parameter MAX_WR, default 2, meaning max outstanding writes (1..4).
REQ-005 SHALL have port clk, in, 1, meaning the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, in, 1, meaning a synchronous, active-high reset.
REQ-007 SHALL have inst_req/inst_wr in 1, inst_size in 2, inst_wstrb in STRB_W, inst_addr in ADDR_W, inst_wdata in DATA_W, meaning the instruction SRAM-like request.
REQ-008 SHALL have inst_rdata out DATA_W, inst_addr_ok out 1, inst_data_ok out 1, meaning the instruction SRAM-like response.
REQ-009 SHALL have the same ports prefixed data_, meaning the data SRAM-like port.
REQ-010 SHALL have AXI3 ar/r ports: arid[3:0], araddr, arlen[7:0], arsize[2:0], arburst[1:0], arlock[1:0], arcache[3:0], arprot[2:0], arvalid out; arready in; rid[3:0], rdata, rresp[1:0], rlast, rvalid in; rready out.
REQ-011 SHALL have AXI3 aw/w/b ports: awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid out; awready in; wid, wdata, wstrb, wlast, wvalid out; wready in; bid, bresp, bvalid in; bready out.

Function
REQ-012 SHALL tie arlen/awlen=0, arburst/awburst=1, lock/cache/prot=0, wlast=1, awid=wid=1; arid=0 for inst, 1 for data.
REQ-013 SHALL drive addr_ok combinationally; a request is accepted in the cycle req && addr_ok.
REQ-014 SHALL accept a read only when arvalid=0 and that port's read count < MAX_RD.
REQ-015 SHALL accept a data read only when the write count = 0, preserving data-port order.
REQ-016 SHALL block an inst read while any pending-write table entry matches addr[ADDR_W-1:log2(STRB_W)].
REQ-017 SHALL arbitrate reads with data over inst when both are eligible in one cycle; the loser sees addr_ok=0.
REQ-018 SHALL accept a data write only when awvalid=0, wvalid=0, write count < MAX_WR, and data read count = 0.
REQ-019 SHALL ignore inst_wr=1 and never assert inst_addr_ok for it.
REQ-020 SHALL, on an accepted request, register address, size ({1'b0,size}), wdata and wstrb, and raise arvalid (or awvalid and wvalid) the next cycle.
REQ-021 SHALL drop each valid independently on its own handshake, holding payload stable until then.
REQ-022 SHALL push the write address into an MAX_WR-entry FIFO on accept and pop it on the b handshake.
REQ-023 SHALL keep counters inst_rd_cnt and data_rd_cnt (inc on accept, dec on r handshake by rid) and wr_cnt (inc on accept, dec on b handshake), unchanged on simultaneous inc and dec.
REQ-024 SHALL tie rready=1.
REQ-025 SHALL drive bready = !(rvalid && rid==1), so data-port completions never collide.
REQ-026 SHALL register rdata into the port selected by rid on an r handshake and pulse that port's data_ok for 1 cycle, one cycle after the handshake.
REQ-027 SHALL pulse data_data_ok one cycle after a b handshake, leaving rdata unchanged.
REQ-028 SHALL ignore rresp and bresp, treating every response as OKAY.
REQ-029 SHALL give minimum read latency req->data_ok = 3 cycles, with arready and rvalid each arriving one cycle after the preceding step.

Reset
REQ-030 SHALL, while reset=1, drive arvalid, awvalid, wvalid, and both addr_ok and data_ok to 0, zero all counters, payload registers and rdata, and empty the write FIFO.
REQ-031 SHALL, on reset mid-transaction, abandon in-flight transactions; the interconnect is reset by the same signal.

Verification
REQ-032 SHALL verify a single inst read at 0x1FC00000 with rdata=0xDEADBEEF: araddr=0x1FC00000, arid=0, inst_data_ok pulse with inst_rdata=0xDEADBEEF, counters return to 0.
REQ-033 SHALL verify a simultaneous inst and data read request: data gets addr_ok first (arid=1), inst accepted after the ar handshake, and responses return in either rid order correctly routed.
REQ-034 SHALL verify a data write to 0x80000010 (wstrb=0xF), then an inst read of 0x80000010 before bvalid: inst_addr_ok=0 until the b handshake, then accepted.
REQ-035 SHALL verify MAX_RD=2 with bvalid and rvalid withheld: a third inst read sees addr_ok=0 until the first r handshake.
REQ-036 SHALL verify rvalid (rid=1) and bvalid in the same cycle: bready=0 that cycle, and two separate data_data_ok pulses.
REQ-037 SHALL verify reset asserted while arvalid=1: arvalid=0 and counts=0 the next cycle, and no data_ok is produced.
